// File: rtl/return_stack.sv
// return_stack: call/return address stack committing once per instruction on the rising edge of aux_push_pop
module return_stack #(
  parameter int DEPTH = 8,
  parameter int AW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       aux_push_pop,
  input  logic [AW-1:0]              push_data,
  input  logic                       flag_clr,
  output logic [AW-1:0]              ret_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       conflict
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] sp;
  logic [CW-1:0] sp_dec;
  logic          aux_q;
  logic          commit;
  logic          do_push;
  logic          do_pop;
  logic          set_ovf;
  logic          set_unf;
  logic          set_cfl;
  assign commit  = aux_push_pop & ~aux_q;
  assign empty   = sp == '0;
  assign full    = sp == CW'(DEPTH);
  assign count   = sp;
  assign sp_dec  = sp - CW'(1);
  assign do_push = commit & push & ~pop & ~full;
  assign do_pop  = commit & pop & ~push & ~empty;
  assign set_ovf = commit & push & ~pop & full;
  assign set_unf = commit & pop & ~push & empty;
  assign set_cfl = commit & push & pop;
  // aux_q resets high so an instruction already in flight at reset release cannot commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_q     <= 1'b1;
      sp        <= '0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      aux_q     <= aux_push_pop;
      sp        <= do_push ? sp + CW'(1) : do_pop ? sp_dec : sp;
      ret_addr  <= do_pop ? mem[sp_dec[PW-1:0]] : ret_addr;
      overflow  <= set_ovf | (overflow & ~flag_clr);
      underflow <= set_unf | (underflow & ~flag_clr);
      conflict  <= set_cfl | (conflict & ~flag_clr);
    end
  end
  // stack storage needs no reset; only entries below sp are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[sp[PW-1:0]] <= push_data;
  end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed self-checking bench for return_stack
module tb_return_stack;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        aux = 1'b0;
  logic        flag_clr = 1'b0;
  logic [31:0] push_data = '0;
  logic [31:0] ret_addr;
  logic [3:0]  count;
  logic        empty, full, overflow, underflow, conflict;
  int checks = 0;
  int errors = 0;

  return_stack #(.DEPTH(8), .AW(32)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .aux_push_pop(aux),
    .push_data(push_data), .flag_clr(flag_clr), .ret_addr(ret_addr), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one instruction: stage with aux low, two stages with aux high (commit at first rising edge), then aux low
  task automatic instr(input logic p, input logic q, input logic [31:0] d);
    @(negedge clk);
    push = p; pop = q; push_data = d; aux = 1'b0;
    @(negedge clk); aux = 1'b1;
    @(negedge clk);
    @(negedge clk); aux = 1'b0;
    @(negedge clk); push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ret", ret_addr, 0);
    reset = 1'b1;
    instr(0, 0, 32'h dead);
    instr(0, 0, 32'h beef);
    check("idle_count", count, 0);
    check("idle_empty", empty, 1);
    check("idle_ret", ret_addr, 0);
    check("idle_flags", {overflow, underflow, conflict}, 0);

    instr(1, 0, 32'h0000_0104);
    check("call_count", count, 1);
    check("call_ret_unchanged", ret_addr, 0);
    instr(0, 1, 32'h0);
    check("ret_count", count, 0);
    check("ret_addr", ret_addr, 32'h104);
    instr(0, 0, 32'h0);
    check("ret_held", ret_addr, 32'h104);

    instr(1, 0, 32'h10);
    instr(1, 0, 32'h20);
    instr(1, 0, 32'h30);
    check("nest_count", count, 3);
    instr(0, 1, 0); check("nest_pop1", ret_addr, 32'h30);
    instr(0, 1, 0); check("nest_pop2", ret_addr, 32'h20);
    instr(0, 1, 0); check("nest_pop3", ret_addr, 32'h10);
    check("nest_empty", empty, 1);

    for (int i = 1; i <= 7; i++) instr(1, 0, 32'h100 + i);
    check("fill7_full", full, 0);
    instr(1, 0, 32'h108);
    check("fill8_full", full, 1);
    check("fill8_ovf", overflow, 0);
    instr(1, 0, 32'h109);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 8);
    instr(0, 1, 0);
    check("ovf_mem7", ret_addr, 32'h108);
    for (int i = 0; i < 7; i++) instr(0, 1, 0);
    check("drain_ret", ret_addr, 32'h101);
    check("drain_unf", underflow, 0);
    instr(0, 1, 0);
    check("unf_flag", underflow, 1);
    check("unf_ret", ret_addr, 32'h101);
    check("unf_count", count, 0);
    check("ovf_sticky", overflow, 1);
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    check("clr_flags", {overflow, underflow}, 0);

    // set wins over clear on the same edge
    @(negedge clk); pop = 1'b1; aux = 1'b1; flag_clr = 1'b1;
    @(negedge clk);
    check("set_wins", underflow, 1);
    flag_clr = 1'b0; aux = 1'b0; pop = 1'b0;
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    check("clr_again", underflow, 0);

    @(negedge clk); push = 1'b1; push_data = 32'h55;
    repeat (4) begin @(negedge clk); aux = 1'b1; end
    @(negedge clk); aux = 1'b0;
    @(negedge clk); push = 1'b0;
    check("one_commit", count, 1);
    instr(1, 1, 32'h66);
    check("conflict_flag", conflict, 1);
    check("conflict_count", count, 1);

    @(negedge clk); push = 1'b1; push_data = 32'h77;
    @(negedge clk); aux = 1'b1;
    #2 reset = 1'b0;
    #1 check("rstmid_count", count, 0);
    check("rstmid_conflict", conflict, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstrel_nocommit", count, 0);
    aux = 1'b0;
    @(negedge clk);
    check("rstrel_low", count, 0);
    aux = 1'b1;
    @(negedge clk);
    check("rstrel_recommit", count, 1);
    aux = 1'b0; push = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware call/return address stack in the ID stage, driven by the control unit's `push`, `pop` and `aux_push_pop` strobes. On CALL (opcode 000011) it pushes the link address presented by the datapath. On RET (opcode 000001) it pops the most recent entry. The popped address is presented on `ret_addr` for the PC mux (pcSrc = 000) before the stage-4 PCWrite edge. Underflow and overflow are reported through sticky error flags.

## Interface
- `DEPTH`, 8: number of stack entries; power of two, 2..64.
- `AW`, 32: address width of stored return addresses.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `push`  in  1: level from the control unit, high for the whole CALL instruction.
- `pop`  in  1: level from the control unit, high for the whole RET instruction.
- `aux_push_pop`  in  1: control-unit qualifier, high during stages 2–3 of each instruction.
- `push_data`  in  AW: link address (PC+4) to store; sampled only at a push commit.
- `flag_clr`  in  1: synchronous clear of the sticky flags.
- `ret_addr`  out  AW: registered address from the last successful pop.
- `count`  out  $clog2(DEPTH+1): current number of valid entries.
- `empty`  out  1: count == 0.
- `full`  out  1: count == DEPTH.
- `overflow`  out  1: sticky; a push was attempted while full.
- `underflow`  out  1: sticky; a pop was attempted while empty.
- `conflict`  out  1: sticky; push and pop were both high at a commit.

## Operation
- Internal register `aux_q` holds `aux_push_pop` from the previous cycle.
- Commit condition: `commit = aux_push_pop & ~aux_q`. It fires exactly once per instruction, on the edge that ends stage 2.
- All stack state changes happen only on a commit edge. Otherwise the stack holds.
- Push commit (push=1, pop=0):
  - Not full: `mem[sp] <= push_data`, `sp <= sp+1`.
  - Full: entry discarded, sp unchanged, `overflow <= 1`.
- Pop commit (pop=1, push=0):
  - Not empty: `ret_addr <= mem[sp-1]`, `sp <= sp-1`.
  - Empty: sp unchanged, ret_addr unchanged, `underflow <= 1`.
- Push and pop both high at a commit: no stack change, `conflict <= 1`.
- Neither push nor pop high at a commit (ordinary instruction): nothing happens.
- `ret_addr` changes only on a successful pop commit. Pushes never alter it.
- `count` equals sp. `empty` and `full` are decoded combinationally from sp.
- Sticky flags:
  - Cleared by reset or by `flag_clr` sampled high at a clock edge.
  - If `flag_clr` and a new error occur on the same edge, the set wins.
- Storage is registers or distributed RAM with a combinational read of `mem[sp-1]`. No reset is required on `mem`.

## Timing
- Reset (asynchronous, `reset` = 0):
  - sp = 0, `ret_addr` = 0, `overflow` = `underflow` = `conflict` = 0.
  - `empty` = 1, `full` = 0, `count` = 0.
  - `aux_q` resets to 1, so a commit cannot fire until `aux_push_pop` has been seen low. This suppresses a spurious commit when reset releases in the middle of an instruction.
- Commit latency: state is updated at the edge ending stage 2. `ret_addr`, `count` and the flags are valid from stage 3. `ret_addr` is therefore stable for stages 3–4 and for the stage-4→0 PCWrite edge.
- `aux_push_pop` held high across several cycles produces one commit only. A new commit requires a 0→1 transition.
- Reset asserted mid-instruction: all state is cleared immediately and any pending push or pop is lost.
- Wrap-around: none; sp saturates at 0 and DEPTH.

## Test plan
- Reset then idle:
  - Hold `reset` = 0 for 2 cycles, release, and drive aux pulses with push = pop = 0.
  - Required: count = 0, empty = 1, `ret_addr` = 0, all flags 0.
- Single call/return:
  - Push commit with `push_data` = 0x0000_0104, then a pop commit.
  - Required: count 1 then 0; `ret_addr` = 0x0000_0104 from the cycle after the pop commit, held through stage 4.
- Nested LIFO:
  - Push 0x10, 0x20, 0x30, then pop three times.
  - Required: `ret_addr` sequence 0x30, 0x20, 0x10; empty = 1 at the end.
- Overflow and underflow (DEPTH = 8):
  - Push 9 times: full = 1 after the 8th push; overflow = 1 after the 9th; count stays 8; `mem[7]` is unchanged.
  - Pop 9 times: after the 9th, underflow = 1, `ret_addr` = the 8th popped value (entry 0), count = 0.
  - Pulse `flag_clr`: both flags return to 0.
- Single commit per instruction:
  - Hold `aux_push_pop` high for 4 cycles with push = 1: exactly one entry pushed.
  - Push = pop = 1 at a commit: conflict = 1 and count unchanged.
- Reset mid-instruction:
  - Assert `reset` while `aux_push_pop` = 1 and push = 1, then release while `aux_push_pop` is still 1.
  - Required: no commit until `aux_push_pop` falls and rises again; count = 0.
